// File: rtl/iob_prbs_rx_checker.sv
// ---------------------------------------------------------------------------
// iob_prbs_rx_checker
//
// Receive-side PRBS7 (x^7+x^6+1) checker for characterizing a tri-stated
// HP-bank output. The pad and a copy of the far-end tri-state control are
// registered. The registered bit stream is checked by a self-synchronising
// LFSR that seeds from the line and then free-runs once locked.
//
// Ports
//   clkin64      : single clock, all logic rising-edge
//   rstin64      : synchronous active-high reset
//   in64         : pad data from the output under test
//   tin64        : far-end tri-state copy, 1 = driver disabled (bit ignored)
//   clr64        : synchronous clear of err/slip/bit counters (lock kept)
//   locked64     : checker locked to the PRBS7 stream
//   err64        : one-cycle pulse per bit error counted while locked
//   err_cnt64    : bit errors while locked, saturating
//   slip_cnt64   : lock losses, saturating
//   bit_cnt64    : bits checked while locked, wrapping
//   state_dbg64  : current checker state (0 SEED, 1 HUNT, 2 LOCKED)
//
// Handshake: there is no flow control. A captured bit is "valid" when the
// registered tri-state copy is 0; invalid bits freeze every piece of state
// and force err64 low.
// ---------------------------------------------------------------------------
module iob_prbs_rx_checker #(
    parameter string       IOSTANDARD = "SSTL15",
    parameter int unsigned LOCK_CNT   = 16,
    parameter int unsigned LOSS_CNT   = 4
) (
    input  logic        clkin64,
    input  logic        rstin64,
    input  logic        in64,
    input  logic        tin64,
    input  logic        clr64,
    output logic        locked64,
    output logic        err64,
    output logic [15:0] err_cnt64,
    output logic [7:0]  slip_cnt64,
    output logic [31:0] bit_cnt64,
    output logic [1:0]  state_dbg64
);

    // Elaboration-time guard on the parameter ranges and pad standard.
    if (LOCK_CNT < 1 || LOCK_CNT > 255 || LOSS_CNT < 1 || LOSS_CNT > 15 ||
        IOSTANDARD == "") begin : g_bad_param
        $error("iob_prbs_rx_checker: parameter out of range");
    end

    typedef enum logic [1:0] {
        ST_SEED   = 2'd0,
        ST_HUNT   = 2'd1,
        ST_LOCKED = 2'd2
    } state_t;

    localparam logic [7:0] LOCK_LAST = 8'(LOCK_CNT - 1);
    localparam logic [3:0] LOSS_LAST = 4'(LOSS_CNT - 1);

    // Input buffers: the implementation flow places IBUFs of IOSTANDARD on
    // these pads; behaviourally they are plain wires.
    logic in_buf;
    logic tin_buf;
    assign in_buf  = in64;
    assign tin_buf = tin64;

    state_t      state_q, state_d;
    logic        d_q, d_d;
    logic        t_q, t_d;
    logic [6:0]  lfsr_q, lfsr_d;
    logic [2:0]  seed_q, seed_d;
    logic [7:0]  match_q, match_d;
    logic [3:0]  miss_q, miss_d;
    logic        locked_q, locked_d;
    logic        err_q, err_d;
    logic [15:0] err_cnt_q, err_cnt_d;
    logic [7:0]  slip_q, slip_d;
    logic [31:0] bit_cnt_q, bit_cnt_d;

    logic       valid;
    logic       pred;
    logic [6:0] lfsr_from_line;
    logic [6:0] lfsr_from_pred;

    always_comb begin
        valid          = ~t_q;
        pred           = lfsr_q[6] ^ lfsr_q[5];
        lfsr_from_line = {lfsr_q[5:0], d_q};
        lfsr_from_pred = {lfsr_q[5:0], pred};

        d_d       = in_buf;
        t_d       = tin_buf;
        state_d   = state_q;
        lfsr_d    = lfsr_q;
        seed_d    = seed_q;
        match_d   = match_q;
        miss_d    = miss_q;
        locked_d  = locked_q;
        err_d     = 1'b0;
        err_cnt_d = err_cnt_q;
        slip_d    = slip_q;
        bit_cnt_d = bit_cnt_q;

        if (valid) begin
            unique case (state_q)
                ST_SEED: begin
                    lfsr_d = lfsr_from_line;
                    if (seed_q == 3'd6) begin
                        seed_d = 3'd0;
                        // An all-zero seed would "match" a dead line forever,
                        // so only a non-zero seed may start the hunt.
                        if (lfsr_from_line != 7'd0) begin
                            state_d = ST_HUNT;
                            match_d = 8'd0;
                        end
                    end else begin
                        seed_d = seed_q + 3'd1;
                    end
                end
                ST_HUNT: begin
                    if (d_q == pred) begin
                        lfsr_d = lfsr_from_pred;
                        if (match_q == LOCK_LAST) begin
                            state_d  = ST_LOCKED;
                            locked_d = 1'b1;
                            miss_d   = 4'd0;
                            match_d  = 8'd0;
                        end else begin
                            match_d = match_q + 8'd1;
                        end
                    end else begin
                        // The failing bit is discarded, seeding restarts fresh.
                        state_d = ST_SEED;
                        seed_d  = 3'd0;
                    end
                end
                ST_LOCKED: begin
                    // Free-running prediction: received bits never enter the
                    // LFSR, so an isolated error cannot corrupt it.
                    lfsr_d    = lfsr_from_pred;
                    bit_cnt_d = bit_cnt_q + 32'd1;
                    if (d_q != pred) begin
                        err_d = 1'b1;
                        if (err_cnt_q != 16'hFFFF) err_cnt_d = err_cnt_q + 16'd1;
                        if (miss_q == LOSS_LAST) begin
                            state_d  = ST_SEED;
                            locked_d = 1'b0;
                            seed_d   = 3'd0;
                            miss_d   = 4'd0;
                            if (slip_q != 8'hFF) slip_d = slip_q + 8'd1;
                        end else begin
                            miss_d = miss_q + 4'd1;
                        end
                    end else begin
                        miss_d = 4'd0;
                    end
                end
                default: begin
                    state_d = ST_SEED;
                    seed_d  = 3'd0;
                end
            endcase
        end

        // Clear beats any increment landing on the same edge.
        if (clr64) begin
            err_cnt_d = 16'd0;
            slip_d    = 8'd0;
            bit_cnt_d = 32'd0;
        end
    end

    always_ff @(posedge clkin64) begin
        if (rstin64) begin
            state_q   <= ST_SEED;
            d_q       <= 1'b0;
            t_q       <= 1'b1;
            lfsr_q    <= 7'd0;
            seed_q    <= 3'd0;
            match_q   <= 8'd0;
            miss_q    <= 4'd0;
            locked_q  <= 1'b0;
            err_q     <= 1'b0;
            err_cnt_q <= 16'd0;
            slip_q    <= 8'd0;
            bit_cnt_q <= 32'd0;
        end else begin
            state_q   <= state_d;
            d_q       <= d_d;
            t_q       <= t_d;
            lfsr_q    <= lfsr_d;
            seed_q    <= seed_d;
            match_q   <= match_d;
            miss_q    <= miss_d;
            locked_q  <= locked_d;
            err_q     <= err_d;
            err_cnt_q <= err_cnt_d;
            slip_q    <= slip_d;
            bit_cnt_q <= bit_cnt_d;
        end
    end

    assign locked64    = locked_q;
    assign err64       = err_q;
    assign err_cnt64   = err_cnt_q;
    assign slip_cnt64  = slip_q;
    assign bit_cnt64   = bit_cnt_q;
    assign state_dbg64 = state_q;

endmodule

// File: tb/tb_iob_prbs_rx_checker.sv
// ---------------------------------------------------------------------------
// tb_iob_prbs_rx_checker
//
// Directed bench for iob_prbs_rx_checker. The driver streams a PRBS7
// pattern (seed 7'h7F) and pushes hand-derived expected status values,
// each tagged with the clock edge after which it must hold, into an
// expected queue. A monitor on the falling edge pops due entries and
// compares them with the DUT outputs.
// ---------------------------------------------------------------------------
module tb_iob_prbs_rx_checker;

    localparam int SEL_LOCKED = 0;
    localparam int SEL_ERR    = 1;
    localparam int SEL_ERRCNT = 2;
    localparam int SEL_SLIP   = 3;
    localparam int SEL_BITCNT = 4;
    localparam int SEL_STATE  = 5;
    localparam int SEL_PULSES = 6;

    localparam logic [31:0] ST_SEED = 32'd0;

    // ---------------- clock / reset ----------------
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rstin64 = 1'b1;
    logic        in64    = 1'b0;
    logic        tin64   = 1'b1;
    logic        clr64   = 1'b0;
    logic        locked64;
    logic        err64;
    logic [15:0] err_cnt64;
    logic [7:0]  slip_cnt64;
    logic [31:0] bit_cnt64;
    logic [1:0]  state_dbg64;

    iob_prbs_rx_checker #(
        .IOSTANDARD("SSTL15"),
        .LOCK_CNT  (16),
        .LOSS_CNT  (4)
    ) dut (
        .clkin64    (clk),
        .rstin64    (rstin64),
        .in64       (in64),
        .tin64      (tin64),
        .clr64      (clr64),
        .locked64   (locked64),
        .err64      (err64),
        .err_cnt64  (err_cnt64),
        .slip_cnt64 (slip_cnt64),
        .bit_cnt64  (bit_cnt64),
        .state_dbg64(state_dbg64)
    );

    int edge_cnt = 0;
    always @(posedge clk) edge_cnt <= edge_cnt + 1;

    // ---------------- scoreboard state ----------------
    logic [31:0] exp_q[$];
    int          exp_at_q[$];
    int          exp_sel_q[$];
    string       exp_name_q[$];

    int n_checks   = 0;
    int n_pass     = 0;
    int err_pulses = 0;

    logic [6:0] gen = 7'h7F;

    // ---------------- driver tasks ----------------
    task automatic drive(input logic b, input logic t);
        in64  = b;
        tin64 = t;
        @(posedge clk);
        #1;
    endtask

    task automatic send_prbs(input int n, input logic inv);
        logic b;
        for (int i = 0; i < n; i++) begin
            b   = gen[6] ^ gen[5];
            gen = {gen[5:0], b};
            drive(b ^ inv, 1'b0);
        end
    endtask

    task automatic chk_at(input int at, input int sel, input logic [31:0] exp,
                          input string name);
        exp_q.push_back(exp);
        exp_at_q.push_back(at);
        exp_sel_q.push_back(sel);
        exp_name_q.push_back(name);
    endtask

    // Expectation for the status after the next edge, i.e. once the last
    // bit already driven has been evaluated.
    task automatic chk(input int sel, input logic [31:0] exp, input string name);
        chk_at(edge_cnt + 1, sel, exp, name);
    endtask

    // Expectation for the status after the edge just taken.
    task automatic chk_now(input int sel, input logic [31:0] exp, input string name);
        chk_at(edge_cnt, sel, exp, name);
    endtask

    function automatic logic [31:0] actual_of(input int sel);
        logic [31:0] v;
        v = 32'hDEAD_BEEF;
        case (sel)
            SEL_LOCKED: v = 32'(locked64);
            SEL_ERR:    v = 32'(err64);
            SEL_ERRCNT: v = 32'(err_cnt64);
            SEL_SLIP:   v = 32'(slip_cnt64);
            SEL_BITCNT: v = bit_cnt64;
            SEL_STATE:  v = 32'(state_dbg64);
            SEL_PULSES: v = 32'(err_pulses);
            default:    v = 32'hDEAD_BEEF;
        endcase
        return v;
    endfunction

    // ---------------- monitor ----------------
    always @(negedge clk) begin : monitor
        logic [31:0] act;
        logic [31:0] exp;
        int          at;
        int          sel;
        string       name;
        if (err64 === 1'b1) err_pulses = err_pulses + 1;
        while (exp_q.size() != 0 && exp_at_q[0] <= edge_cnt) begin
            exp  = exp_q.pop_front();
            at   = exp_at_q.pop_front();
            sel  = exp_sel_q.pop_front();
            name = exp_name_q.pop_front();
            act  = actual_of(sel);
            n_checks = n_checks + 1;
            if (at == edge_cnt && act === exp) begin
                n_pass = n_pass + 1;
            end else begin
                $display("FAIL %s: edge %0d (due %0d) got 0x%0h, expected 0x%0h",
                         name, edge_cnt, at, act, exp);
            end
        end
    end

    initial begin : watchdog
        #1ms;
        $display("FAIL watchdog: simulation did not finish, %0d/%0d done", n_pass, n_checks);
        $fatal(1, "watchdog expired");
    end

    // ---------------- stimulus ----------------
    initial begin : stim
        int e0;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk_now(SEL_LOCKED, 32'd0, "rst_locked");
        chk_now(SEL_ERR,    32'd0, "rst_err");
        chk_now(SEL_ERRCNT, 32'd0, "rst_errcnt");
        chk_now(SEL_SLIP,   32'd0, "rst_slip");
        chk_now(SEL_BITCNT, 32'd0, "rst_bitcnt");
        chk_now(SEL_STATE,  ST_SEED, "rst_state");
        rstin64 = 1'b0;

        // Clean stream: lock after the 24th edge counting the first capture edge
        e0 = edge_cnt + 1;
        chk_at(e0 + 22, SEL_LOCKED, 32'd0, "lock_not_yet");
        chk_at(e0 + 23, SEL_LOCKED, 32'd1, "lock_edge24");
        send_prbs(23, 1'b0);
        send_prbs(1000, 1'b0);
        chk(SEL_BITCNT, 32'd1000, "clean_bitcnt");
        chk(SEL_ERRCNT, 32'd0,    "clean_errcnt");
        chk(SEL_SLIP,   32'd0,    "clean_slip");
        chk(SEL_LOCKED, 32'd1,    "clean_locked");

        // Single inverted bit
        send_prbs(1, 1'b1);
        chk(SEL_ERR,    32'd1, "single_err_pulse");
        chk(SEL_ERRCNT, 32'd1, "single_errcnt");
        chk(SEL_LOCKED, 32'd1, "single_locked");
        chk(SEL_PULSES, 32'd1, "single_pulses");
        chk_at(edge_cnt + 2, SEL_ERR, 32'd0, "single_err_drop");
        send_prbs(20, 1'b0);
        chk(SEL_ERRCNT, 32'd1, "after_single_errcnt");
        chk(SEL_PULSES, 32'd1, "after_single_pulses");

        // Error on every third bit, ten times
        for (int i = 0; i < 10; i++) begin
            send_prbs(2, 1'b0);
            send_prbs(1, 1'b1);
        end
        chk(SEL_ERRCNT, 32'd11,   "sparse_errcnt");
        chk(SEL_SLIP,   32'd0,    "sparse_slip");
        chk(SEL_LOCKED, 32'd1,    "sparse_locked");
        chk(SEL_PULSES, 32'd11,   "sparse_pulses");
        chk(SEL_BITCNT, 32'd1051, "sparse_bitcnt");

        // Four consecutive errors cause a slip, then relock 23 bits later
        send_prbs(5, 1'b0);
        clr64 = 1'b1;
        send_prbs(1, 1'b0);
        clr64 = 1'b0;
        chk_now(SEL_ERRCNT, 32'd0, "clr_errcnt");
        chk_now(SEL_BITCNT, 32'd0, "clr_bitcnt");
        send_prbs(3, 1'b1);
        chk(SEL_LOCKED, 32'd1, "three_err_locked");
        chk(SEL_ERRCNT, 32'd3, "three_err_errcnt");
        send_prbs(1, 1'b1);
        chk(SEL_LOCKED, 32'd0,  "slip_unlocked");
        chk(SEL_ERRCNT, 32'd4,  "slip_errcnt");
        chk(SEL_SLIP,   32'd1,  "slip_cnt");
        chk(SEL_STATE,  ST_SEED, "slip_state");
        chk(SEL_PULSES, 32'd15, "slip_pulses");
        chk_at(edge_cnt + 23, SEL_LOCKED, 32'd0, "relock_not_yet");
        chk_at(edge_cnt + 24, SEL_LOCKED, 32'd1, "relock");
        send_prbs(23, 1'b0);

        // Tri-stated gap with garbage on the pad
        send_prbs(10, 1'b0);
        clr64 = 1'b1;
        send_prbs(1, 1'b0);
        clr64 = 1'b0;
        send_prbs(20, 1'b0);
        for (int i = 0; i < 50; i++) drive(1'($urandom_range(0, 1)), 1'b1);
        chk(SEL_BITCNT, 32'd21, "tri_bitcnt_frozen");
        chk(SEL_LOCKED, 32'd1,  "tri_locked");
        send_prbs(30, 1'b0);
        chk(SEL_BITCNT, 32'd51, "tri_bitcnt");
        chk(SEL_ERRCNT, 32'd0,  "tri_errcnt");
        chk(SEL_LOCKED, 32'd1,  "tri_locked_after");
        chk(SEL_PULSES, 32'd15, "tri_pulses");

        // Reset while locked with five errors counted
        for (int i = 0; i < 5; i++) begin
            send_prbs(1, 1'b1);
            send_prbs(2, 1'b0);
        end
        chk(SEL_ERRCNT, 32'd5,  "prerst_errcnt");
        chk(SEL_LOCKED, 32'd1,  "prerst_locked");
        chk(SEL_PULSES, 32'd20, "prerst_pulses");
        send_prbs(1, 1'b0);
        rstin64 = 1'b1;
        send_prbs(1, 1'b0);
        rstin64 = 1'b0;
        chk_now(SEL_LOCKED, 32'd0, "midrst_locked");
        chk_now(SEL_ERR,    32'd0, "midrst_err");
        chk_now(SEL_ERRCNT, 32'd0, "midrst_errcnt");
        chk_now(SEL_SLIP,   32'd0, "midrst_slip");
        chk_now(SEL_BITCNT, 32'd0, "midrst_bitcnt");
        chk_now(SEL_STATE,  ST_SEED, "midrst_state");
        e0 = edge_cnt + 1;
        chk_at(e0 + 22, SEL_LOCKED, 32'd0, "rstlock_not_yet");
        chk_at(e0 + 23, SEL_LOCKED, 32'd1, "rstlock_edge24");
        send_prbs(23, 1'b0);

        // Clear on the same edge as an error evaluation
        send_prbs(3, 1'b0);
        send_prbs(1, 1'b1);
        clr64 = 1'b1;
        send_prbs(1, 1'b0);
        clr64 = 1'b0;
        chk_now(SEL_ERRCNT, 32'd0,  "clr_vs_err_errcnt");
        chk_now(SEL_ERR,    32'd1,  "clr_vs_err_pulse");
        chk_now(SEL_LOCKED, 32'd1,  "clr_vs_err_locked");
        chk_now(SEL_PULSES, 32'd21, "clr_vs_err_pulses");
        send_prbs(3, 1'b0);
        chk(SEL_ERRCNT, 32'd0, "clr_vs_err_after");

        // Stuck-low line never locks and stays in SEED
        rstin64 = 1'b1;
        drive(1'b0, 1'b0);
        rstin64 = 1'b0;
        for (int i = 0; i < 10; i++) begin
            repeat (10) drive(1'b0, 1'b0);
            chk(SEL_STATE,  ST_SEED, "zero_state");
            chk(SEL_LOCKED, 32'd0,   "zero_locked");
        end

        // Drain
        repeat (5) drive(1'b0, 1'b1);
        while (exp_q.size() != 0) begin
            n_checks = n_checks + 1;
            $display("FAIL %s: never compared, due edge %0d, expected 0x%0h",
                     exp_name_q[0], exp_at_q[0], exp_q[0]);
            void'(exp_q.pop_front());
            void'(exp_at_q.pop_front());
            void'(exp_sel_q.pop_front());
            void'(exp_name_q.pop_front());
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/iob_prbs_rx_checker.md
# iob_prbs_rx_checker

Receive-side companion to the HP-bank OBUFT output characterization designs. It takes the single-ended pad driven by the tri-state output under test through an input buffer, registers it, and checks the bit stream against a self-synchronising PRBS7 pattern (x^7+x^6+1). It reports lock, bit errors and lock slips so the bank 64 output path can be characterized in hardware. Cycles where the far-end driver is tri-stated are excluded from checking.

## Interface
- IOSTANDARD, "SSTL15": I/O standard of the pad input buffers for in64 and tin64.
- LOCK_CNT, 16: consecutive matching checked bits required to declare lock (range 1..255).
- LOSS_CNT, 4: consecutive mismatches while locked that drop lock (range 1..15).
- clkin64  input  1  single clock; all logic is rising-edge; drives tristate-sample and data capture flops.
- rstin64  input  1  synchronous, active-high reset.
- in64  input  1  pad data from the DUT output; passes through an IBUF of IOSTANDARD.
- tin64  input  1  far-end tri-state control copy, 1 = driver disabled; passes through an IBUF of IOSTANDARD.
- clr64  input  1  synchronous clear of err_cnt64, slip_cnt64 and bit_cnt64; does not affect lock state.
- locked64  output  1  checker locked to the PRBS7 stream.
- err64  output  1  one-cycle pulse per bit error counted while locked.
- err_cnt64  output  16  bit errors while locked; saturates at 16'hFFFF.
- slip_cnt64  output  8  lock losses; saturates at 8'hFF.
- bit_cnt64  output  32  bits checked while locked; wraps modulo 2^32.

## Operation
- Capture stage: d_q <= in64 and t_q <= tin64 on every edge. A bit is valid when t_q == 0. Invalid cycles freeze the FSM, the LFSR, the match/miss counters and all outputs except err64, which is 0.
- LFSR s[6:0]: predicted bit p = s[6]^s[5]; shift is s <= {s[5:0], x}.
- SEED: shift x = d_q on each valid bit. After 7 valid bits, go to HUNT with match = 0.
- HUNT: compare d_q with p.
  - Match: shift p; match++. When match reaches LOCK_CNT, go to LOCKED, assert locked64, set miss = 0.
  - Mismatch: go to SEED with the seed count cleared. The mismatching bit is not used as a seed bit.
- LOCKED: each valid bit increments bit_cnt64 and shifts p. The received bit is never shifted in, so isolated errors do not desynchronise the LFSR.
  - Mismatch: err64 = 1, err_cnt64++ (saturating), miss++.
  - Match: miss = 0.
  - When miss reaches LOSS_CNT: go to SEED, clear locked64, slip_cnt64++ (saturating). The error on that bit is still counted.
- LFSR reaching all-zero in SEED (stuck-low line) causes HUNT to match forever on constant 0. The checker therefore requires s != 0 at the SEED→HUNT transition; otherwise it restarts SEED.
- clr64 together with a counter increment in the same cycle: clr64 wins, and the counter reads 0 after the edge.
- Reset values: locked64 = 0, err64 = 0, err_cnt64 = 0, slip_cnt64 = 0, bit_cnt64 = 0, state = SEED, seed/match/miss counts = 0, LFSR = 0, d_q = 0, t_q = 1. Reset mid-operation returns to SEED on the next edge, regardless of state.

## Timing
- Bit k is presented at the pad before edge k and captured at edge k. The FSM evaluates it at edge k+1, and outputs reflect it after edge k+1. Latency is therefore 2 edges pad-to-status.
- From reset release with a continuous valid clean stream: 7 seed bits plus LOCK_CNT checks. With default parameters, locked64 rises after edge 24 counted from the first valid bit's capture edge.
- err64 is high for exactly the cycle following evaluation of the errored bit.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Test plan
- Clean PRBS7 stream, seed 7'h7F, tin64 = 0: locked64 rises after edge 24. After 1000 further bits: bit_cnt64 = 1000, err_cnt64 = 0, slip_cnt64 = 0.
- Locked stream, single bit inverted: err64 pulses once, err_cnt64 = 1, locked64 stays 1, and subsequent bits match. Errors then injected every 3rd bit 10 times: err_cnt64 = 11, no slip.
- Locked stream, then 4 consecutive inverted bits: locked64 falls after the 4th error's evaluation edge, err_cnt64 = 4, slip_cnt64 = 1. Relock occurs 23 valid bits later.
- tin64 = 1 for 50 cycles mid-stream with garbage on in64, and the stream resumes without skipped bits: no errors, locked64 held, bit_cnt64 excludes the 50 cycles.
- Constant-0 input: locked64 never asserts, and the FSM cycles through SEED. clr64 asserted on the same edge as an error: err_cnt64 reads 0 afterwards.
- rstin64 pulsed while locked with err_cnt64 = 5: after the reset edge, all outputs are 0. Relock follows the 24-edge latency.
